// File: rtl/sysctrl_host_pkg.sv
// Shared definitions for the sysctrl host: command codes, FSM state encoding
// and the payload-length clamp.
package sysctrl_host_pkg;

  localparam logic [7:0] CMD_STATUS  = 8'h00;
  localparam logic [7:0] CMD_LEDS    = 8'h01;
  localparam logic [7:0] CMD_COLOR   = 8'h02;
  localparam logic [7:0] CMD_BUTTONS = 8'h03;
  localparam logic [7:0] CMD_CONFIG  = 8'h04;
  localparam logic [7:0] CMD_IRQ     = 8'h05;
  localparam logic [7:0] CMD_IRQ_SRC = 8'h06;
  localparam logic [7:0] CMD_PORT    = 8'h07;
  localparam logic [7:0] CMD_MENU    = 8'h08;

  localparam logic [4:0] MAX_LEN = 5'd16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT,
    PAYLOAD,
    CAPTURE,
    DONE
  } state_t;

  function automatic logic [4:0] clamp_len(input logic [4:0] len);
    return (len > MAX_LEN) ? MAX_LEN : len;
  endfunction

endpackage

// File: rtl/sysctrl_host.sv
// Byte-serial host for the sysctrl companion: frames user requests as a start
// byte plus payload, and autonomously polls/acks the interrupt line when idle.
module sysctrl_host
  import sysctrl_host_pkg::*;
#(
  parameter int GAP          = 3,
  parameter int POLL_HOLDOFF = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_cmd,
  input  logic [4:0] req_len,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       done,
  output logic       data_in_strobe,
  output logic       data_in_start,
  output logic [7:0] data_in,
  input  logic [7:0] data_out,
  input  logic       int_out_n,
  input  logic       poll_en,
  output logic [7:0] irq_vec,
  output logic [7:0] irq_src,
  output logic       irq_upd,
  output state_t     dbg_state
);

  localparam int HW = $clog2(POLL_HOLDOFF + 1);
  localparam logic [3:0] WAIT_FROM_START   = 4'(GAP - 1);
  localparam logic [3:0] WAIT_FROM_CAPTURE = 4'((GAP > 1) ? GAP - 2 : 0);

  state_t          state;
  logic [7:0]      cmd_q;
  logic [4:0]      remain;
  logic [3:0]      wait_cnt;
  logic            polling;
  logic [1:0]      poll_step;
  logic [HW-1:0]   holdoff;
  logic [7:0]      poll_byte;
  logic            byte_avail;

  // Handshakes: req and tx transfer on a clock edge where valid and ready are
  // both high; ready never depends on anything but state and the own valid.
  always_comb begin
    poll_byte      = (poll_step == 2'd2) ? {7'b0, irq_vec[0]} : 8'h00;
    byte_avail     = polling | tx_valid;
    req_ready      = (state == IDLE);
    tx_ready       = (state == PAYLOAD) && !polling && tx_valid;
    data_in_start  = (state == START);
    data_in_strobe = (state == START) || ((state == PAYLOAD) && byte_avail);
    data_in        = 8'h00;
    if (state == START)
      data_in = cmd_q;
    else if ((state == PAYLOAD) && byte_avail)
      data_in = polling ? poll_byte : tx_data;
    rsp_valid      = (state == CAPTURE) && !polling;
    rsp_data       = rsp_valid ? data_out : 8'h00;
    done           = (state == DONE) && !polling;
    dbg_state      = state;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cmd_q     <= 8'h00;
      remain    <= 5'd0;
      wait_cnt  <= 4'd0;
      polling   <= 1'b0;
      poll_step <= 2'd0;
      holdoff   <= '0;
      irq_vec   <= 8'h00;
      irq_src   <= 8'h00;
      irq_upd   <= 1'b0;
    end else begin
      irq_upd <= 1'b0;
      if (holdoff != '0) holdoff <= holdoff - HW'(1);
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            cmd_q   <= req_cmd;
            remain  <= clamp_len(req_len);
            polling <= 1'b0;
            state   <= START;
          end else if (poll_en && !int_out_n && (holdoff == '0)) begin
            cmd_q     <= CMD_IRQ;
            remain    <= 5'd1;
            polling   <= 1'b1;
            poll_step <= 2'd0;
            state     <= START;
          end
        end
        START: begin
          wait_cnt <= WAIT_FROM_START;
          state    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
          else state <= (remain != 5'd0) ? PAYLOAD : DONE;
        end
        PAYLOAD: begin
          if (byte_avail) begin
            remain <= remain - 5'd1;
            state  <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (polling && (poll_step == 2'd0)) irq_vec <= data_out;
          if (polling && (poll_step == 2'd1)) irq_src <= data_out;
          // This cycle already counts toward the inter-strobe gap.
          if (GAP > 1) begin
            wait_cnt <= WAIT_FROM_CAPTURE;
            state    <= WAIT;
          end else begin
            state <= (remain != 5'd0) ? PAYLOAD : DONE;
          end
        end
        DONE: begin
          if (polling && (poll_step != 2'd2)) begin
            cmd_q     <= (poll_step == 2'd0) ? CMD_IRQ_SRC : CMD_IRQ;
            remain    <= 5'd1;
            poll_step <= poll_step + 2'd1;
            state     <= START;
          end else begin
            if (polling) begin
              irq_upd <= 1'b1;
              holdoff <= HW'(POLL_HOLDOFF);
            end
            polling <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sysctrl_host.sv
// Bench for sysctrl_host with a behavioural sysctrl responder; randomized
// frames are checked against a frame-level reference model.
module tb_sysctrl_host;
  import sysctrl_host_pkg::*;

  localparam int GAP  = 3;
  localparam int HOLD = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0, req_ready;
  logic [7:0] req_cmd = 8'h00;
  logic [4:0] req_len = 5'd0;
  logic       tx_valid = 1'b0, tx_ready;
  logic [7:0] tx_data = 8'h00;
  logic       rsp_valid, done;
  logic [7:0] rsp_data;
  logic       data_in_strobe, data_in_start;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       int_out_n;
  logic       poll_en = 1'b0;
  logic [7:0] irq_vec, irq_src;
  logic       irq_upd;
  state_t     dbg_state;

  always #5 clk = ~clk;

  sysctrl_host #(.GAP(GAP), .POLL_HOLDOFF(HOLD)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd), .req_len(req_len),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .done(done),
    .data_in_strobe(data_in_strobe), .data_in_start(data_in_start), .data_in(data_in),
    .data_out(data_out), .int_out_n(int_out_n), .poll_en(poll_en),
    .irq_vec(irq_vec), .irq_src(irq_src), .irq_upd(irq_upd), .dbg_state(dbg_state)
  );

  // Behavioural sysctrl: registers a response on every non-start strobe.
  logic       sys_rst = 1'b1;
  logic       irq_raise = 1'b0;
  logic [7:0] sys_cmd;
  int         sys_idx;
  logic [7:0] irq_flags;
  logic [1:0] leds;

  always @(posedge clk) begin
    if (sys_rst) begin
      data_out <= 8'h00; sys_cmd <= 8'h00; sys_idx <= 0; irq_flags <= 8'h01; leds <= 2'b00;
    end else begin
      if (irq_raise) irq_flags <= irq_flags | 8'h01;
      if (data_in_strobe && data_in_start) begin
        sys_cmd <= data_in;
        sys_idx <= 0;
      end else if (data_in_strobe) begin
        sys_idx <= sys_idx + 1;
        case (sys_cmd)
          CMD_STATUS:  data_out <= (sys_idx == 0) ? 8'h5C : (sys_idx == 1) ? 8'h42 : 8'h00;
          CMD_LEDS: begin
            data_out <= 8'h00;
            if (sys_idx == 0) leds <= data_in[1:0];
          end
          CMD_IRQ: begin
            data_out  <= irq_flags;
            irq_flags <= irq_flags & ~data_in;
          end
          CMD_IRQ_SRC: data_out <= 8'h01;
          default:     data_out <= ~data_in;
        endcase
      end
    end
  end
  assign int_out_n = (irq_flags == 8'h00);

  // Monitor: records bus strobes, responses and pulses; sole writer of these.
  int         cyc = 0, done_cnt = 0, upd_cnt = 0, txr_cnt = 0, upd_t = 0;
  int         bad_width = 0, bad_txr = 0, bad_rsp = 0;
  logic [8:0] bus_q[$];
  int         bus_t[$];
  logic [7:0] rsp_q[$];
  logic       prev_strobe = 1'b0;
  logic       user_frame = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      prev_strobe = 1'b0;
    end else begin
      if (data_in_strobe) begin
        bus_q.push_back({data_in_start, data_in});
        bus_t.push_back(cyc);
        if (prev_strobe) bad_width++;
      end
      prev_strobe = data_in_strobe;
      if (tx_ready && !(tx_valid && user_frame)) bad_txr++;
      if (tx_ready && tx_valid) txr_cnt++;
      if (rsp_valid) begin
        rsp_q.push_back(rsp_data);
        if (!user_frame) bad_rsp++;
      end
      if (done) done_cnt++;
      if (irq_upd) begin
        upd_cnt++;
        upd_t = cyc;
      end
    end
  end

  int         asserts = 0, failures = 0;
  logic [7:0] pay[32];
  int         stall[32];

  function automatic logic [7:0] exp_rsp(input logic [7:0] cmd, input int idx, input logic [7:0] b);
    if (cmd == CMD_STATUS) return (idx == 0) ? 8'h5C : (idx == 1) ? 8'h42 : 8'h00;
    if (cmd == CMD_LEDS) return 8'h00;
    return ~b;
  endfunction

  task automatic send_frame(input logic [7:0] cmd, input int len, input bit with_poll);
    int n, t, d0;
    n = (len > 16) ? 16 : len;
    d0 = done_cnt;
    user_frame = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b1; req_cmd = cmd; req_len = 5'(len);
    if (with_poll) poll_en = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!req_ready && t < 100);
    asserts++;
    if (!req_ready) begin failures++; $display("FAIL req_accept: req_ready=%0b expected 1", req_ready); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      repeat (stall[i]) begin @(posedge clk); #1; end
      tx_valid = 1'b1; tx_data = pay[i];
      t = 0;
      do begin @(negedge clk); t++; end while (!tx_ready && t < 200);
      asserts++;
      if (!tx_ready) begin failures++; $display("FAIL tx_ready_timeout: byte %0d tx_ready=%0b expected 1", i, tx_ready); end
      @(posedge clk); #1;
      tx_valid = 1'b0;
    end
    t = 0;
    while (done_cnt == d0 && t < 200) begin @(negedge clk); t++; end
    asserts++;
    if (done_cnt == d0) begin failures++; $display("FAIL done_timeout: done pulses=%0d expected %0d", done_cnt - d0, 1); end
    user_frame = 1'b0;
  endtask

  task automatic wait_upd(input int u0);
    int t = 0;
    while (upd_cnt == u0 && t < 400) begin @(negedge clk); t++; end
    asserts++;
    if (upd_cnt == u0) begin failures++; $display("FAIL upd_timeout: irq_upd count=%0d expected %0d", upd_cnt, u0 + 1); end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1; reset = 1'b0; sys_rst = 1'b0;
    @(negedge clk);
    asserts++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_req_ready: got %0b expected 1", req_ready); end
    asserts++; if (dbg_state !== IDLE) begin failures++; $display("FAIL rst_state: got %0d expected %0d", dbg_state, IDLE); end
    asserts++; if ({data_in_strobe, data_in_start, tx_ready, rsp_valid, done, irq_upd} !== 6'b0) begin
      failures++; $display("FAIL rst_pulses: got %b expected 000000", {data_in_strobe, data_in_start, tx_ready, rsp_valid, done, irq_upd}); end
    asserts++; if (data_in !== 8'h00) begin failures++; $display("FAIL rst_data_in: got %h expected 00", data_in); end
    asserts++; if ({irq_vec, irq_src} !== 16'h0000) begin failures++; $display("FAIL rst_irq_regs: got %h expected 0000", {irq_vec, irq_src}); end
  endtask

  task automatic test_poll();
    logic [8:0] exp9[6];
    int b0, r0, d0, u0, t, delta;
    exp9 = '{{1'b1, CMD_IRQ}, 9'h000, {1'b1, CMD_IRQ_SRC}, 9'h000, {1'b1, CMD_IRQ}, 9'h001};
    b0 = bus_q.size(); r0 = rsp_q.size(); d0 = done_cnt; u0 = upd_cnt;
    @(posedge clk); #1; poll_en = 1'b1;
    wait_upd(u0);
    @(negedge clk);
    asserts++; if (bus_q.size() != b0 + 6) begin failures++; $display("FAIL poll_strobes: got %0d expected 6", bus_q.size() - b0); end
    for (int i = 0; i < 6 && b0 + i < bus_q.size(); i++) begin
      asserts++; if (bus_q[b0 + i] !== exp9[i]) begin failures++; $display("FAIL poll_bus[%0d]: got %h expected %h", i, bus_q[b0 + i], exp9[i]); end
    end
    asserts++; if (irq_vec !== 8'h01) begin failures++; $display("FAIL poll_irq_vec: got %h expected 01", irq_vec); end
    asserts++; if (irq_src !== 8'h01) begin failures++; $display("FAIL poll_irq_src: got %h expected 01", irq_src); end
    asserts++; if (int_out_n !== 1'b1) begin failures++; $display("FAIL poll_ack: int_out_n=%0b expected 1", int_out_n); end
    asserts++; if (upd_cnt != u0 + 1) begin failures++; $display("FAIL poll_upd_once: got %0d expected 1", upd_cnt - u0); end
    asserts++; if (rsp_q.size() != r0 || done_cnt != d0) begin
      failures++; $display("FAIL poll_silent: rsp=%0d done=%0d expected 0 0", rsp_q.size() - r0, done_cnt - d0); end
    // New interrupt right after the poll must wait out the holdoff.
    @(posedge clk); #1; irq_raise = 1'b1;
    @(posedge clk); #1; irq_raise = 1'b0;
    b0 = bus_q.size(); u0 = upd_cnt; t = 0;
    while (bus_q.size() == b0 && t < 200) begin @(negedge clk); t++; end
    delta = (bus_q.size() > b0) ? bus_t[b0] - upd_t : -1;
    asserts++; if (delta != HOLD + 1) begin failures++; $display("FAIL poll_holdoff: repoll after %0d cycles expected %0d", delta, HOLD + 1); end
    wait_upd(u0);
    @(posedge clk); #1; poll_en = 1'b0;
  endtask

  task automatic test_status();
    int b0, r0;
    b0 = bus_q.size(); r0 = rsp_q.size();
    for (int i = 0; i < 3; i++) begin pay[i] = 8'h00; stall[i] = 0; end
    send_frame(CMD_STATUS, 3, 1'b0);
    asserts++; if (rsp_q.size() != r0 + 3) begin failures++; $display("FAIL status_count: got %0d expected 3", rsp_q.size() - r0); end
    for (int i = 0; i < 3 && r0 + i < rsp_q.size(); i++) begin
      asserts++; if (rsp_q[r0 + i] !== exp_rsp(CMD_STATUS, i, 8'h00)) begin
        failures++; $display("FAIL status_rsp[%0d]: got %h expected %h", i, rsp_q[r0 + i], exp_rsp(CMD_STATUS, i, 8'h00)); end
    end
    for (int i = 1; i < 4 && b0 + i < bus_t.size(); i++) begin
      asserts++; if (bus_t[b0 + i] - bus_t[b0 + i - 1] != GAP + 1) begin
        failures++; $display("FAIL status_spacing[%0d]: got %0d expected %0d", i, bus_t[b0 + i] - bus_t[b0 + i - 1], GAP + 1); end
    end
  endtask

  task automatic test_leds();
    int b0;
    b0 = bus_q.size();
    pay[0] = 8'h02; stall[0] = 0;
    send_frame(CMD_LEDS, 1, 1'b0);
    asserts++; if (leds !== 2'b10) begin failures++; $display("FAIL leds_value: got %b expected 10", leds); end
    asserts++; if (bus_q.size() != b0 + 2 || bus_t[b0 + 1] - bus_t[b0] != GAP + 1) begin
      failures++; $display("FAIL leds_spacing: strobes=%0d expected 2 with period %0d", bus_q.size() - b0, GAP + 1); end
  endtask

  task automatic test_stall();
    int b0, r0;
    b0 = bus_q.size(); r0 = rsp_q.size();
    pay[0] = 8'h3A; pay[1] = 8'hC5; stall[0] = 0; stall[1] = 10;
    send_frame(CMD_PORT, 2, 1'b0);
    asserts++; if (bus_q.size() != b0 + 3) begin failures++; $display("FAIL stall_strobes: got %0d expected 3", bus_q.size() - b0); end
    asserts++; if (bus_q.size() == b0 + 3 && bus_t[b0 + 2] - bus_t[b0 + 1] != 11) begin
      failures++; $display("FAIL stall_timing: got %0d expected 11", bus_t[b0 + 2] - bus_t[b0 + 1]); end
    asserts++; if (rsp_q.size() != r0 + 2 || rsp_q[r0 + 1] !== ~pay[1]) begin
      failures++; $display("FAIL stall_rsp: count %0d last %h expected 2 %h", rsp_q.size() - r0, rsp_q[rsp_q.size() - 1], ~pay[1]); end
  endtask

  task automatic test_random();
    logic [7:0] cmd;
    logic [7:0] cmds[3];
    int len, n, b0, r0, x0, d0, sel;
    cmds = '{CMD_STATUS, CMD_LEDS, CMD_PORT};
    for (int f = 0; f < 12; f++) begin
      sel = $urandom_range(0, 2);
      cmd = cmds[sel];
      len = (f == 0) ? 19 : (f == 1) ? 0 : $urandom_range(0, 20);
      n = (len > 16) ? 16 : len;
      for (int i = 0; i < 32; i++) begin pay[i] = 8'($urandom); stall[i] = $urandom_range(0, 3); end
      b0 = bus_q.size(); r0 = rsp_q.size(); x0 = txr_cnt; d0 = done_cnt;
      send_frame(cmd, len, 1'b0);
      @(negedge clk);
      asserts++; if (bus_q.size() != b0 + n + 1) begin failures++; $display("FAIL rnd%0d_strobes: got %0d expected %0d", f, bus_q.size() - b0, n + 1); end
      asserts++; if (bus_q[b0] !== {1'b1, cmd}) begin failures++; $display("FAIL rnd%0d_start: got %h expected %h", f, bus_q[b0], {1'b1, cmd}); end
      for (int i = 0; i < n && b0 + 1 + i < bus_q.size(); i++) begin
        asserts++; if (bus_q[b0 + 1 + i] !== {1'b0, pay[i]}) begin
          failures++; $display("FAIL rnd%0d_bus[%0d]: got %h expected %h", f, i, bus_q[b0 + 1 + i], {1'b0, pay[i]}); end
        asserts++; if (bus_t[b0 + 1 + i] - bus_t[b0 + i] < GAP + 1) begin
          failures++; $display("FAIL rnd%0d_spacing[%0d]: got %0d expected >= %0d", f, i, bus_t[b0 + 1 + i] - bus_t[b0 + i], GAP + 1); end
      end
      asserts++; if (rsp_q.size() != r0 + n) begin failures++; $display("FAIL rnd%0d_rsp_count: got %0d expected %0d", f, rsp_q.size() - r0, n); end
      for (int i = 0; i < n && r0 + i < rsp_q.size(); i++) begin
        asserts++; if (rsp_q[r0 + i] !== exp_rsp(cmd, i, pay[i])) begin
          failures++; $display("FAIL rnd%0d_rsp[%0d]: got %h expected %h", f, i, rsp_q[r0 + i], exp_rsp(cmd, i, pay[i])); end
      end
      asserts++; if (txr_cnt - x0 != n || done_cnt - d0 != 1) begin
        failures++; $display("FAIL rnd%0d_counts: tx=%0d done=%0d expected %0d 1", f, txr_cnt - x0, done_cnt - d0, n); end
      if (cmd == CMD_LEDS && n > 0) begin
        asserts++; if (leds !== pay[0][1:0]) begin failures++; $display("FAIL rnd%0d_leds: got %b expected %b", f, leds, pay[0][1:0]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int t, d0, r0;
    d0 = done_cnt;
    user_frame = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b1; req_cmd = CMD_STATUS; req_len = 5'd3;
    t = 0;
    do begin @(negedge clk); t++; end while (!req_ready && t < 100);
    @(posedge clk); #1;
    req_valid = 1'b0; tx_valid = 1'b1; tx_data = 8'h00;
    for (int k = 0; k < 2; k++) begin
      t = 0;
      do begin @(negedge clk); t++; end while (!tx_ready && t < 200);
      asserts++; if (!tx_ready) begin failures++; $display("FAIL mid_byte%0d: tx_ready=%0b expected 1", k, tx_ready); end
      if (k == 0) begin @(posedge clk); #1; end
    end
    reset = 1'b1;
    @(posedge clk); #1; tx_valid = 1'b0;
    @(posedge clk); #1; reset = 1'b0; user_frame = 1'b0;
    repeat (30) @(negedge clk);
    asserts++; if (done_cnt != d0) begin failures++; $display("FAIL mid_no_done: got %0d expected 0", done_cnt - d0); end
    r0 = rsp_q.size();
    for (int i = 0; i < 3; i++) begin pay[i] = 8'h00; stall[i] = 0; end
    send_frame(CMD_STATUS, 3, 1'b0);
    asserts++; if (rsp_q.size() != r0 + 3 || rsp_q[r0] !== 8'h5C) begin
      failures++; $display("FAIL mid_resync: count %0d first %h expected 3 5c", rsp_q.size() - r0, rsp_q[r0]); end
  endtask

  task automatic test_priority();
    int b0, r0, d0, u0;
    @(posedge clk); #1; irq_raise = 1'b1;
    @(posedge clk); #1; irq_raise = 1'b0;
    @(negedge clk);
    asserts++; if (int_out_n !== 1'b0) begin failures++; $display("FAIL prio_irq_pending: got %0b expected 0", int_out_n); end
    b0 = bus_q.size(); r0 = rsp_q.size(); d0 = done_cnt; u0 = upd_cnt;
    send_frame(CMD_CONFIG, 0, 1'b1);
    wait_upd(u0);
    @(negedge clk);
    asserts++; if (bus_q.size() != b0 + 7) begin failures++; $display("FAIL prio_strobes: got %0d expected 7", bus_q.size() - b0); end
    asserts++; if (bus_q[b0] !== {1'b1, CMD_CONFIG} || bus_q[b0 + 1] !== {1'b1, CMD_IRQ}) begin
      failures++; $display("FAIL prio_order: got %h %h expected %h %h", bus_q[b0], bus_q[b0 + 1], {1'b1, CMD_CONFIG}, {1'b1, CMD_IRQ}); end
    asserts++; if (rsp_q.size() != r0 || done_cnt != d0 + 1) begin
      failures++; $display("FAIL prio_len0: rsp=%0d done=%0d expected 0 1", rsp_q.size() - r0, done_cnt - d0); end
    asserts++; if (int_out_n !== 1'b1) begin failures++; $display("FAIL prio_ack: got %0b expected 1", int_out_n); end
    poll_en = 1'b0;
  endtask

  task automatic test_protocol();
    asserts++; if (bad_width != 0) begin failures++; $display("FAIL strobe_width: %0d long strobes expected 0", bad_width); end
    asserts++; if (bad_txr != 0) begin failures++; $display("FAIL tx_ready_idle: %0d cycles expected 0", bad_txr); end
    asserts++; if (bad_rsp != 0) begin failures++; $display("FAIL rsp_in_poll: %0d cycles expected 0", bad_rsp); end
  endtask

  initial begin
    test_reset();
    test_poll();
    test_status();
    test_leds();
    test_stall();
    test_random();
    test_reset_mid();
    test_priority();
    test_protocol();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule

// File: doc/sysctrl_host.md
SYSCTRL_HOST -- requirements
Module: sysctrl_host

Interface
REQ-001 Parameter GAP, 3, idle cycles inserted between consecutive data_in_strobe pulses (range 1..15).
REQ-002 Parameter POLL_HOLDOFF, 64, cycles after a completed interrupt poll before int_out_n is sampled again.
REQ-003 clk  in  1  clock; reset  in  1  synchronous, active-high.
REQ-004 req_valid  in  1  frame request; req_ready  out  1  host idle, request accepted when both high.
REQ-005 req_cmd  in  8  command byte; req_len  in  5  payload byte count, 0..16.
REQ-006 tx_valid  in  1; tx_data  in  8; tx_ready  out  1  payload byte stream, transfer when both high.
REQ-007 rsp_valid  out  1; rsp_data  out  8  one response byte per payload byte.
REQ-008 done  out  1  single-cycle pulse, frame finished.
REQ-009 data_in_strobe  out  1; data_in_start  out  1; data_in  out  8  byte bus to sysctrl.
REQ-010 data_out  in  8  sysctrl response; int_out_n  in  1  sysctrl interrupt, active low.
REQ-011 poll_en  in  1  enables autonomous interrupt polling.
REQ-012 irq_vec  out  8  last CMD5 response; irq_src  out  8  last CMD6 response; irq_upd  out  1  pulse when both updated.

Function
REQ-013 States: IDLE, START, WAIT, PAYLOAD, CAPTURE, DONE.
REQ-014 IDLE: req_ready=1; req_valid accepted -> latch cmd/len -> START.
REQ-015 START: one cycle of strobe=1, start=1, data_in=cmd; then WAIT.
REQ-016 WAIT: GAP cycles with strobe=0; then PAYLOAD if bytes remain, else DONE.
REQ-017 PAYLOAD: while tx_valid=0 hold with strobe=0 (no timeout); when tx_valid=1: strobe=1, start=0, data_in=tx_data, tx_ready=1 in that same cycle -> CAPTURE.
REQ-018 CAPTURE: one cycle; rsp_valid=1, rsp_data=data_out (byte registered by sysctrl on the preceding strobe edge); then WAIT; counts as first GAP cycle.
REQ-019 Strobe pulses always exactly one cycle; minimum strobe period GAP+1 cycles.
REQ-020 req_len=0: START, WAIT, DONE; no rsp_valid, no tx_ready.
REQ-021 DONE: done=1 for one cycle -> IDLE; req_ready low in all states except IDLE.
REQ-022 tx_ready and rsp_valid never high outside PAYLOAD/CAPTURE respectively.
REQ-023 Poll sequence (internal frames, tx/rsp ports silent, req_ready=0): CMD5 payload 0x00 -> irq_vec; CMD6 payload 0x00 -> irq_src; CMD5 payload {7'b0, irq_vec[0]} (ack); then irq_upd pulse, holdoff counter loads POLL_HOLDOFF.
REQ-024 Poll starts from IDLE only when poll_en=1, int_out_n=0, holdoff counter=0, and req_valid=0; a user request in the same cycle wins.
REQ-025 Holdoff counter decrements to 0 saturating; poll_en=0 does not abort an in-progress poll.
REQ-026 req_len>16 is clamped to 16.

Reset
REQ-027 On reset: state IDLE, all strobes/pulses 0, data_in=0x00, irq_vec=0x00, irq_src=0x00, holdoff=0, req_ready=1 one cycle after reset release.
REQ-028 Reset mid-frame abandons the frame with no done pulse; next frame begins with a start byte so sysctrl resynchronises.

Structure
REQ-029 Shared package holds command codes (CMD_STATUS=0, CMD_LEDS=1, CMD_COLOR=2, CMD_BUTTONS=3, CMD_CONFIG=4, CMD_IRQ=5, CMD_IRQ_SRC=6, CMD_PORT=7, CMD_MENU=8) and the state enum.
REQ-030 Single module, no sub-modules; the poll sequencer is a step counter inside the main FSM.

Verification (bench instantiates sysctrl as the responder)
REQ-031 Request cmd=0x00, len=3, payload 0,0,0 -> rsp_data 0x5C, 0x42, 0x00, then done.
REQ-032 cmd=0x01, len=1, payload 0x02 -> sysctrl leds=2'b10; strobe spacing exactly GAP+1 cycles.
REQ-033 poll_en=1 after reset -> CMD5 returns 0x01, CMD6 returns 0x01 (coldboot), ack clears int_out_n; irq_upd pulses once; no re-poll for 64 cycles.
REQ-034 tx_valid low for 10 cycles before the second payload byte -> no strobe, no tx_ready during the stall; frame completes correctly after it.
REQ-035 Reset asserted during the second payload byte of a len=3 frame -> no done pulse; following cmd=0x00 frame returns 0x5C first.
REQ-036 len=0 and a simultaneous req_valid with pending poll -> user frame first, poll afterwards.
